// File: rtl/mem_fi.sv
// rtl/mem_fi.sv - single-port word memory with registered read, clear sequencer and bit-flip fault injection
//
// Purpose:
//   Storage element for Hamming/SEC-DED codec experiments. Codewords are
//   written through data_in. Faults are XOR-flipped in place through the
//   injection port. Reads are registered (1-cycle latency, read-old on
//   collisions). After every reset a sweep clears the whole array, one word
//   per cycle, while busy is high.
//
// Parameters:
//   DATA_W  stored word width (codeword width)
//   ADDR_W  address width, depth = 2**ADDR_W
//   CNT_W   width of the saturating injection counter
//
// Ports:
//   clk       in   clock, all state on rising edge
//   rst       in   synchronous active-high reset
//   wr_en     in   write strobe for addr/data_in
//   rd_en     in   read strobe for addr
//   addr      in   shared read/write address
//   data_in   in   write data
//   inj_en    in   fault-injection strobe
//   inj_addr  in   word to corrupt
//   inj_mask  in   bits to flip (XOR mask)
//   data_out  out  registered read data
//   rd_valid  out  one-cycle pulse, data_out is new
//   busy      out  clear sweep in progress, all strobes ignored
//   inj_cnt   out  count of nonzero-mask injections, saturating

module mem_fi #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              inj_en,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [DATA_W-1:0] inj_mask,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  inj_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]    inj_cnt_q, inj_cnt_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Two array write ports: port A carries the clear sweep or the user
    // write, port B carries an injection to a word other than the one
    // being written.
    logic                pa_en;
    logic [ADDR_W-1:0]   pa_addr;
    logic [DATA_W-1:0]   pa_data;
    logic                pb_en;
    logic [ADDR_W-1:0]   pb_addr;
    logic [DATA_W-1:0]   pb_data;

    logic                inj_on_write;

    // A write and an injection hitting the same word merge into a single
    // store of data_in ^ inj_mask (fault on store).
    assign inj_on_write = wr_en && inj_en && (addr == inj_addr);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        inj_cnt_d  = inj_cnt_q;
        pa_en      = 1'b0;
        pa_addr    = addr;
        pa_data    = data_in;
        pb_en      = 1'b0;
        pb_addr    = inj_addr;
        pb_data    = mem[inj_addr] ^ inj_mask;

        unique case (state_q)
            ST_INIT: begin
                pa_en   = 1'b1;
                pa_addr = ptr_q;
                pa_data = '0;
                // ptr wraps back to 0 on the last word
                ptr_d   = ptr_q + ADDR_W'(1);
                if (ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Array reads here see the pre-edge contents: read-old
                if (rd_en) begin
                    data_out_d = mem[addr];
                    rd_valid_d = 1'b1;
                end
                if (wr_en) begin
                    pa_en   = 1'b1;
                    pa_addr = addr;
                    pa_data = inj_on_write ? (data_in ^ inj_mask) : data_in;
                end
                if (inj_en && !inj_on_write) begin
                    pb_en = 1'b1;
                end
                if (inj_en && (inj_mask != '0) && (inj_cnt_q != '1)) begin
                    inj_cnt_d = inj_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            inj_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            inj_cnt_q  <= inj_cnt_d;
        end
    end

    // The array has no reset of its own: it is only cleared by the sweep
    // that follows reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (pa_en) begin
                mem[pa_addr] <= pa_data;
            end
            if (pb_en) begin
                mem[pb_addr] <= pb_data;
            end
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == ST_INIT);
    assign inj_cnt  = inj_cnt_q;

endmodule

// File: tb/tb_mem_fi.sv
// tb/tb_mem_fi.sv - scoreboard testbench for mem_fi (default, CNT_W=2 and 39x64 configurations)

module tb_mem_fi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // default configuration, also shared by the CNT_W=2 instance
    logic        wr_en = 1'b0, rd_en = 1'b0, inj_en = 1'b0;
    logic [3:0]  addr = '0, inj_addr = '0;
    logic [11:0] data_in = '0, inj_mask = '0;
    logic [11:0] data_out;
    logic        rd_valid, busy;
    logic [7:0]  inj_cnt;

    logic [11:0] sat_data_out;
    logic        sat_rd_valid, sat_busy;
    logic [1:0]  sat_cnt;

    // wide configuration
    logic        w_wr_en = 1'b0, w_rd_en = 1'b0, w_inj_en = 1'b0;
    logic [5:0]  w_addr = '0, w_inj_addr = '0;
    logic [38:0] w_data_in = '0, w_inj_mask = '0;
    logic [38:0] w_data_out;
    logic        w_rd_valid, w_busy;
    logic [7:0]  w_inj_cnt;

    mem_fi u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .data_in(data_in), .inj_en(inj_en), .inj_addr(inj_addr), .inj_mask(inj_mask),
        .data_out(data_out), .rd_valid(rd_valid), .busy(busy), .inj_cnt(inj_cnt)
    );

    mem_fi #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .data_in(data_in), .inj_en(inj_en), .inj_addr(inj_addr), .inj_mask(inj_mask),
        .data_out(sat_data_out), .rd_valid(sat_rd_valid), .busy(sat_busy), .inj_cnt(sat_cnt)
    );

    mem_fi #(.DATA_W(39), .ADDR_W(6)) u_wide (
        .clk(clk), .rst(rst), .wr_en(w_wr_en), .rd_en(w_rd_en), .addr(w_addr),
        .data_in(w_data_in), .inj_en(w_inj_en), .inj_addr(w_inj_addr), .inj_mask(w_inj_mask),
        .data_out(w_data_out), .rd_valid(w_rd_valid), .busy(w_busy), .inj_cnt(w_inj_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] qa[$];
    logic [63:0] qw[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse consumes one expected read value
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (qa.size() == 0) check("a_unexpected_rd_valid", 64'd1, 64'd0);
            else                check("a_read_data", 64'(data_out), qa.pop_front());
        end
        if (w_rd_valid === 1'b1) begin
            if (qw.size() == 0) check("w_unexpected_rd_valid", 64'd1, 64'd0);
            else                check("w_read_data", 64'(w_data_out), qw.pop_front());
        end
    end

    task automatic op_a(input bit wr, input bit rd, input bit inj, input int a,
                        input logic [11:0] d, input int ia, input logic [11:0] m,
                        input logic [11:0] exp);
        wr_en = wr; rd_en = rd; inj_en = inj;
        addr = a[3:0]; data_in = d; inj_addr = ia[3:0]; inj_mask = m;
        if (rd) qa.push_back(64'(exp));
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; inj_en = 1'b0;
    endtask

    task automatic op_w(input bit wr, input bit rd, input bit inj, input int a,
                        input logic [38:0] d, input int ia, input logic [38:0] m,
                        input logic [38:0] exp);
        w_wr_en = wr; w_rd_en = rd; w_inj_en = inj;
        w_addr = a[5:0]; w_data_in = d; w_inj_addr = ia[5:0]; w_inj_mask = m;
        if (rd) qw.push_back(64'(exp));
        @(posedge clk); #1;
        w_wr_en = 1'b0; w_rd_en = 1'b0; w_inj_en = 1'b0;
    endtask

    // Counts edges until busy drops, bounded
    task automatic wait_clear(input bit wide, input int exp_n, input string name);
        int n = 0;
        while ((wide ? w_busy : busy) === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(n), 64'(exp_n));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_data_out", 64'(data_out), 64'd0);
        check("reset_inj_cnt", 64'(inj_cnt), 64'd0);
        rst = 1'b0;
        wait_clear(1'b0, 16, "first_clear_cycles");

        // preload 0xABC everywhere, one sanity read, one injection
        for (int i = 0; i < 16; i++) op_a(1, 0, 0, i, 12'hABC, 0, 12'h000, 12'h000);
        op_a(0, 1, 0, 2, 12'h000, 0, 12'h000, 12'hABC);
        op_a(0, 0, 1, 0, 12'h000, 15, 12'h001, 12'h000);
        check("pre_reset_inj_cnt", 64'(inj_cnt), 64'd1);

        // reset pulse with all strobes held high through the sweep
        rst = 1'b1;
        wr_en = 1'b1; rd_en = 1'b1; inj_en = 1'b1;
        addr = 4'd0; data_in = 12'hFFF; inj_addr = 4'd1; inj_mask = 12'hFFF;
        @(posedge clk); #1;
        rst = 1'b0;
        check("pulse_busy", 64'(busy), 64'd1);
        check("pulse_rd_valid", 64'(rd_valid), 64'd0);
        check("pulse_data_out", 64'(data_out), 64'd0);
        check("pulse_inj_cnt", 64'(inj_cnt), 64'd0);
        wait_clear(1'b0, 16, "pulse_clear_cycles");
        wr_en = 1'b0; rd_en = 1'b0; inj_en = 1'b0;
        check("busy_inj_ignored", 64'(inj_cnt), 64'd0);
        for (int i = 0; i < 16; i++) op_a(0, 1, 0, i, 12'h000, 0, 12'h000, 12'h000);

        // write / read, rd_valid pulse shape
        op_a(1, 0, 0, 5, 12'h5A3, 0, 12'h000, 12'h000);
        op_a(0, 1, 0, 5, 12'h000, 0, 12'h000, 12'h5A3);
        check("rd_valid_pulse", 64'(rd_valid), 64'd1);
        op_a(0, 0, 0, 0, 12'h000, 0, 12'h000, 12'h000);
        check("rd_valid_drop", 64'(rd_valid), 64'd0);
        check("data_out_hold", 64'(data_out), 64'h5A3);
        op_a(0, 1, 0, 5, 12'h000, 0, 12'h000, 12'h5A3);
        check("b2b_valid_1", 64'(rd_valid), 64'd1);
        op_a(0, 1, 0, 6, 12'h000, 0, 12'h000, 12'h000);
        check("b2b_valid_2", 64'(rd_valid), 64'd1);
        op_a(0, 0, 0, 0, 12'h000, 0, 12'h000, 12'h000);
        check("b2b_valid_end", 64'(rd_valid), 64'd0);

        // injection, zero mask is not counted
        op_a(1, 0, 0, 3, 12'h0F0, 0, 12'h000, 12'h000);
        op_a(0, 0, 1, 0, 12'h000, 3, 12'h001, 12'h000);
        op_a(0, 0, 1, 0, 12'h000, 3, 12'h000, 12'h000);
        op_a(0, 1, 0, 3, 12'h000, 0, 12'h000, 12'h0F1);
        check("inj_cnt_one", 64'(inj_cnt), 64'd1);

        // simultaneous events
        op_a(1, 0, 0, 7, 12'h111, 0, 12'h000, 12'h000);
        op_a(1, 1, 1, 7, 12'h222, 7, 12'h800, 12'h111);
        op_a(0, 1, 0, 7, 12'h000, 0, 12'h000, 12'hA22);
        check("inj_cnt_two", 64'(inj_cnt), 64'd2);
        op_a(1, 0, 1, 8, 12'h123, 9, 12'h00F, 12'h000);
        op_a(0, 1, 0, 8, 12'h000, 0, 12'h000, 12'h123);
        op_a(0, 1, 0, 9, 12'h000, 0, 12'h000, 12'h00F);
        op_a(0, 1, 1, 8, 12'h000, 8, 12'h100, 12'h123);
        op_a(0, 1, 0, 8, 12'h000, 0, 12'h000, 12'h023);
        op_a(0, 0, 1, 0, 12'h000, 10, 12'h001, 12'h000);
        check("inj_cnt_five", 64'(inj_cnt), 64'd5);
        check("sat_cnt", 64'(sat_cnt), 64'd3);
        op_a(0, 0, 0, 0, 12'h000, 0, 12'h000, 12'h000);
        check("sat_busy", 64'(sat_busy), 64'd0);
        check("sat_rd_valid", 64'(sat_rd_valid), 64'd0);
        check("sat_data_out", 64'(sat_data_out), 64'h023);

        // reset during the sweep restarts it
        pulse_rst();
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("mid_init_busy", 64'(busy), 64'd1);
        pulse_rst();
        wait_clear(1'b0, 16, "mid_init_restart");
        op_a(0, 1, 0, 5, 12'h000, 0, 12'h000, 12'h000);
        op_a(0, 1, 0, 8, 12'h000, 0, 12'h000, 12'h000);
        op_a(0, 1, 0, 12, 12'h000, 0, 12'h000, 12'h000);
        check("mid_init_inj_cnt", 64'(inj_cnt), 64'd0);

        // wide configuration: 64-word sweep and 39-bit flips
        pulse_rst();
        wait_clear(1'b1, 64, "wide_clear_cycles");
        op_w(1, 0, 0, 40, 39'h12_3456_789A, 0, 39'h0, 39'h0);
        op_w(0, 0, 1, 0, 39'h0, 40, 39'h40_0000_0001, 39'h0);
        op_w(0, 1, 0, 40, 39'h0, 0, 39'h0, 39'h52_3456_789B);
        check("wide_inj_cnt_one", 64'(w_inj_cnt), 64'd1);
        op_w(0, 1, 0, 63, 39'h0, 0, 39'h0, 39'h0);
        op_w(1, 1, 1, 63, 39'h00_0000_00FF, 63, 39'h7F_FFFF_FFFF, 39'h0);
        op_w(0, 1, 0, 63, 39'h0, 0, 39'h0, 39'h7F_FFFF_FF00);
        op_w(1, 0, 1, 0, 39'h55_5555_5555, 1, 39'h40_0000_0000, 39'h0);
        op_w(0, 1, 0, 0, 39'h0, 0, 39'h0, 39'h55_5555_5555);
        op_w(0, 1, 0, 1, 39'h0, 0, 39'h0, 39'h40_0000_0000);
        check("wide_inj_cnt_three", 64'(w_inj_cnt), 64'd3);

        repeat (2) begin
            @(posedge clk); #1;
        end
        check("a_queue_drained", 64'(qa.size()), 64'd0);
        check("w_queue_drained", 64'(qw.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_fi.md
# mem_fi

Parametrised single-port word memory with a registered read, a multi-cycle clear sequencer and a bit-flip fault-injection port. It is the storage element for the Hamming/SEC-DED codec experiments: codewords are written through `data_in`, and faults are flipped in place through the injection port. Reads are then checked by the downstream decoder. Width and depth are parameters so the same block serves every code length in the family.

## Interface
- `DATA_W`, default 12: stored word width in bits (codeword width).
- `ADDR_W`, default 4: address width. Depth is 2^ADDR_W words.
- `CNT_W`, default 8: width of the injection event counter.

- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `wr_en`  in  1: write strobe for `addr`/`data_in`.
- `rd_en`  in  1: read strobe for `addr`.
- `addr`  in  ADDR_W: shared read/write address.
- `data_in`  in  DATA_W: write data.
- `inj_en`  in  1: fault-injection strobe.
- `inj_addr`  in  ADDR_W: word to corrupt.
- `inj_mask`  in  DATA_W: bits to flip (XOR mask).
- `data_out`  out  DATA_W: registered read data.
- `rd_valid`  out  1: one-cycle pulse, `data_out` is new.
- `busy`  out  1: clear sequence in progress. All strobes are ignored while high.
- `inj_cnt`  out  CNT_W: count of effective injections, saturating.

## Operation
- FSM states: INIT and IDLE. `busy` = (state == INIT).
- Reset:
  - Any edge with `rst`=1 sets state to INIT, the clear pointer `ptr` to 0, `data_out` to 0, `rd_valid` to 0 and `inj_cnt` to 0.
  - No array word is cleared while `rst` is high.
- INIT:
  - Each edge with `rst`=0 writes 0 to word `ptr`, then increments `ptr`.
  - The edge that clears word 2^ADDR_W−1 moves the state to IDLE. `ptr` wraps to 0 and is unused in IDLE.
  - `wr_en`, `rd_en` and `inj_en` are ignored. `rd_valid` stays 0 and `inj_cnt` is unchanged.
- IDLE, write: `wr_en`=1 sets mem[addr] to `data_in`.
- IDLE, read:
  - `rd_en`=1 loads mem[addr] into `data_out` and sets `rd_valid`=1 for the next cycle.
  - When `rd_en`=0, `rd_valid` goes to 0 and `data_out` holds its last value.
- IDLE, inject: `inj_en`=1 sets mem[inj_addr] to mem[inj_addr] XOR `inj_mask`.
- `inj_cnt` increments on each IDLE edge with `inj_en`=1 and `inj_mask` != 0. It saturates at 2^CNT_W−1. A zero mask is a legal no-op and is not counted.
- Simultaneous events in IDLE, same edge:
  - Write and inject to the same word: mem gets `data_in` XOR `inj_mask`. This models a fault on store.
  - Write and inject to different words: both take effect.
  - Read and write to the same word: read-old. `data_out` gets the pre-write contents.
  - Read and inject to the same word: read-old, uncorrupted value.
  - Read, write and inject all on one word: `data_out` gets the old value and mem gets `data_in` XOR `inj_mask`.
- Reset mid-INIT: the sequence restarts at `ptr`=0. Words already cleared stay 0.
- Reset in IDLE: array contents are not cleared until the following INIT sweep.

## Timing
- Clear latency: with `rst` sampled low at edge E1, edges E1 through E(2^ADDR_W) clear words 0 through 2^ADDR_W−1. `busy` falls after edge E(2^ADDR_W); the default config gives 16 cycles. The first accepted strobe is at edge E(2^ADDR_W+1).
- Read latency: 1 cycle. A strobe sampled at edge N gives `data_out`/`rd_valid` valid after edge N. Back-to-back reads every cycle are supported, with `rd_valid` held high.
- Write and inject latency: 0. A word written or injected at edge N is visible to a read sampled at edge N+1.
- Outputs after any reset edge: `data_out`=0, `rd_valid`=0, `busy`=1, `inj_cnt`=0.

## Test plan
- Reset and clear:
  - Preload all words with 0xABC, pulse `rst` for 1 cycle.
  - Required: `busy` high for exactly 16 cycles, then every word reads 0x000.
  - Strobes issued during `busy` have no effect.
- Write/read:
  - Write word 5 = 0x5A3, then read 5 next cycle.
  - Required: `data_out`=0x5A3 with `rd_valid` high for 1 cycle.
  - Then read 5 and 6 back-to-back: `rd_valid` stays high for 2 cycles.
- Injection:
  - Word 3 = 0x0F0; inject addr 3 with mask 0x001, then mask 0x000.
  - Required: word 3 reads 0x0F1 and `inj_cnt`=1.
- Simultaneous events:
  - Word 7 = 0x111. Same edge: write 7 = 0x222, inject 7 with mask 0x800, read 7.
  - Required: `data_out`=0x111, next read = 0xA22.
- Counter saturation:
  - With CNT_W=2, apply 5 nonzero injections.
  - Required: `inj_cnt`=3.
- Reset mid-INIT and parameterisation:
  - Assert `rst` at clear cycle 8. Required: `busy` high for a further 16 cycles.
  - Rerun all scenarios at DATA_W=39, ADDR_W=6. Required: 64-cycle clear and a 39-bit mask flip correct.
